alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one `alu` instance between two requesters (req0, req1) using round-robin arbitration and valid/ready handshakes on each side.
- Accepted operations are executed combinationally by the shared `alu`.
- The result is registered into a 1-entry output buffer, tagged with the requester ID, and held until consumed.
- Sits between the issue logic and the writeback/consumer in the pd0 datapath.

Parameters:
- DWIDTH, 8, operand/result width; passed through to the `alu` instance.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  synchronous active-low reset
- req0_valid_i  input  1  requester 0 has an operation
- req0_ready_o  output  1  requester 0 operation accepted this cycle
- req0_sel_i  input  2  ALU op for requester 0 (constants_pkg: ADD=0, SUB=1, AND=2, OR=3)
- req0_op1_i  input  DWIDTH  operand 1, requester 0
- req0_op2_i  input  DWIDTH  operand 2, requester 0
- req1_valid_i, req1_ready_o, req1_sel_i, req1_op1_i, req1_op2_i  as above, for requester 1
- res_valid_o  output  1  output buffer holds a result
- res_ready_i  input  1  consumer accepts the result
- res_o  output  DWIDTH  registered result
- res_id_o  output  1  requester that produced res_o
- zero_o  output  1  registered: res_o == 0
- neg_o  output  1  registered: res_o[DWIDTH-1]

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - res_valid_o=0; res_o=0; res_id_o=0; zero_o=0; neg_o=0.
  - Round-robin pointer last_grant=1, so req0 has first priority.
  - Reset mid-operation drops any buffered result with no handshake.
- Buffer free condition: can_accept = !res_valid_o || res_ready_i. A full buffer being drained in the same cycle is treated as free.
- Grant is combinational:
  - Only one valid: grant it if can_accept.
  - Both valid: grant the requester != last_grant.
  - reqN_ready_o = can_accept && grant==N.
  - At most one ready is high per cycle.
  - Ready never asserts when can_accept=0.
- Mux: the granted requester's sel/op1/op2 drive the `alu` instance. With no grant, mux to req0 inputs; the result is unused.
- On an accept edge (any ready&&valid):
  - res_o <= alu result
  - res_id_o <= granted ID
  - zero_o <= (result==0)
  - neg_o <= result[DWIDTH-1]
  - res_valid_o <= 1
  - last_grant <= granted ID
- Flag rules:
  - Flags are computed in this block from the alu result, not taken from the alu's flag outputs.
  - zero and neg are never both 1.
- Latency: accept at edge N → res_valid_o=1 after edge N. One op per cycle sustained while res_ready_i=1.
- Drain: res_valid_o && res_ready_i && no accept → res_valid_o <= 0. Drain plus accept in the same cycle → buffer reloads and res_valid_o stays 1.
- Stall: res_valid_o && !res_ready_i → res_o, res_id_o, zero_o, neg_o are held stable; both readys are 0.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DWIDTH; no carry/overflow output.
  - SUB is op1 - op2.
  - AND/OR are bitwise.
- last_grant updates only on accept; idle cycles do not rotate priority.
- Requesters must hold valid and operands stable until ready; the block does not register inputs before grant.
- State: single-bit pointer plus output buffer. Two-state buffer FSM (EMPTY, FULL):
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL otherwise.

Test Plan:
- Reset, then req0 only, sel=ADD, op1=8'h05, op2=8'h03, res_ready_i=1 → req0_ready_o=1 that cycle. Next cycle: res_valid_o=1, res_o=8'h08, res_id_o=0, zero_o=0, neg_o=0.
- Both valid continuously: req0 SUB 8'h03-8'h05, req1 AND 8'hF0&8'h0F, res_ready_i=1 → grants alternate 0,1,0,1. Results are 8'hFE (neg_o=1, id 0) then 8'h00 (zero_o=1, id 1).
- Backpressure: res_ready_i=0 after a first result of OR 8'h80|8'h01 → res_o=8'h81 and neg_o=1 held for 5 cycles with both readys 0. Raising res_ready_i accepts the pending request in the same cycle.
- Wrap: ADD 8'hFF+8'h01 → res_o=8'h00, zero_o=1, neg_o=0.
- Drain with no new request → res_valid_o falls 1 cycle after the handshake. last_grant is unchanged after 3 idle cycles: with last grant to req1, the next contention goes to req0.
- rst_ni=0 for one edge while res_valid_o=1 and both requests valid → all outputs 0, no ready asserted that cycle. After release, the first contention is granted to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// The result sits in a one-entry buffer until the consumer takes it.
package constants_pkg;
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_sel_e;
endpackage

module alu #(
  parameter int DWIDTH = 8
) (
  input  logic [1:0]        sel_i,
  input  logic [DWIDTH-1:0] op1_i,
  input  logic [DWIDTH-1:0] op2_i,
  output logic [DWIDTH-1:0] res_o
);
  import constants_pkg::*;

  always_comb begin
    res_o = '0;
    unique case (alu_sel_e'(sel_i))
      ALU_ADD: res_o = op1_i + op2_i;
      ALU_SUB: res_o = op1_i - op2_i;
      ALU_AND: res_o = op1_i & op2_i;
      ALU_OR:  res_o = op1_i | op2_i;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [1:0]        req0_sel_i,
  input  logic [DWIDTH-1:0] req0_op1_i,
  input  logic [DWIDTH-1:0] req0_op2_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [1:0]        req1_sel_i,
  input  logic [DWIDTH-1:0] req1_op1_i,
  input  logic [DWIDTH-1:0] req1_op2_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              res_id_o,
  output logic              zero_o,
  output logic              neg_o
);
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  buf_state_e        state_q;
  logic              last_q;
  logic [DWIDTH-1:0] res_q;
  logic              res_id_q;
  logic              zero_q;
  logic              neg_q;

  logic              can_accept;
  logic              gnt;
  logic              accept;
  logic [1:0]        alu_sel;
  logic [DWIDTH-1:0] alu_a;
  logic [DWIDTH-1:0] alu_b;
  logic [DWIDTH-1:0] alu_res;

  assign can_accept = (state_q == EMPTY) || res_ready_i;

  always_comb begin
    gnt = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      gnt = ~last_q;
    end else if (req1_valid_i) begin
      gnt = 1'b1;
    end
  end

  // Readys are held low while in reset so nothing looks accepted.
  assign req0_ready_o = rst_ni && can_accept
                        && req0_valid_i && !gnt;
  assign req1_ready_o = rst_ni && can_accept
                        && req1_valid_i && gnt;
  assign accept = req0_ready_o || req1_ready_o;

  assign alu_sel = gnt ? req1_sel_i : req0_sel_i;
  assign alu_a   = gnt ? req1_op1_i : req0_op1_i;
  assign alu_b   = gnt ? req1_op2_i : req0_op2_i;

  alu #(
    .DWIDTH(DWIDTH)
  ) u_alu (
    .sel_i(alu_sel),
    .op1_i(alu_a),
    .op2_i(alu_b),
    .res_o(alu_res)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= EMPTY;
      last_q   <= 1'b1;
      res_q    <= '0;
      res_id_q <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      if (accept) begin
        res_q    <= alu_res;
        res_id_q <= gnt;
        zero_q   <= ~|alu_res;
        neg_q    <= alu_res[DWIDTH-1];
        last_q   <= gnt;
      end
      unique case (state_q)
        EMPTY: if (accept) state_q <= FULL;
        FULL:  if (res_ready_i && !accept) state_q <= EMPTY;
      endcase
    end
  end

  assign res_valid_o = (state_q == FULL);
  assign res_o       = res_q;
  assign res_id_o    = res_id_q;
  assign zero_o      = zero_q;
  assign neg_o       = neg_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter.
// Directed vectors; a negedge monitor checks each consumed result.
module tb_alu_arbiter;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req0_valid_i = 1'b0;
  logic       req0_ready_o;
  logic [1:0] req0_sel_i = 2'd0;
  logic [7:0] req0_op1_i = 8'h00;
  logic [7:0] req0_op2_i = 8'h00;
  logic       req1_valid_i = 1'b0;
  logic       req1_ready_o;
  logic [1:0] req1_sel_i = 2'd0;
  logic [7:0] req1_op1_i = 8'h00;
  logic [7:0] req1_op2_i = 8'h00;
  logic       res_valid_o;
  logic       res_ready_i = 1'b1;
  logic [7:0] res_o;
  logic       res_id_o;
  logic       zero_o;
  logic       neg_o;

  localparam logic [1:0] ADD = 2'd0;
  localparam logic [1:0] SUB = 2'd1;
  localparam logic [1:0] AND = 2'd2;
  localparam logic [1:0] OR  = 2'd3;

  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       z;
    logic       n;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  alu_arbiter #(.DWIDTH(8)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req0_valid_i(req0_valid_i),
    .req0_ready_o(req0_ready_o),
    .req0_sel_i(req0_sel_i),
    .req0_op1_i(req0_op1_i),
    .req0_op2_i(req0_op2_i),
    .req1_valid_i(req1_valid_i),
    .req1_ready_o(req1_ready_o),
    .req1_sel_i(req1_sel_i),
    .req1_op1_i(req1_op1_i),
    .req1_op2_i(req1_op2_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_o(res_o),
    .res_id_o(res_id_o),
    .zero_o(zero_o),
    .neg_o(neg_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: pops one expectation per consumed result.
  always @(negedge clk_i) begin
    if (rst_ni && res_valid_o && res_ready_i) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_result: got id=%0d res=%h, none expected",
                 res_id_o, res_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (res_id_o !== e.id || res_o !== e.res ||
            zero_o !== e.z || neg_o !== e.n) begin
          nerr++;
          $display("FAIL result: got id=%0d res=%h z=%0d n=%0d, want id=%0d res=%h z=%0d n=%0d",
                   res_id_o, res_o, zero_o, neg_o, e.id, e.res, e.z, e.n);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic id, input logic [7:0] r,
                      input logic z, input logic n);
    exp_t e;
    e.id = id;
    e.res = r;
    e.z = z;
    e.n = n;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic id, input logic v, input logic [1:0] s,
                       input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req1_valid_i = v; req1_sel_i = s;
      req1_op1_i = a; req1_op2_i = b;
    end else begin
      req0_valid_i = v; req0_sel_i = s;
      req0_op1_i = a; req0_op2_i = b;
    end
  endtask

  // Waits for n handshakes (seen at negedge, taken at next posedge).
  task automatic wait_hs(input int n);
    int hs;
    int cyc;
    hs = 0;
    cyc = 0;
    while (hs < n && cyc < 50) begin
      @(negedge clk_i);
      if (req0_ready_o && req1_ready_o) begin
        nvec++;
        nerr++;
        $display("FAIL one_hot_ready: both readys high");
      end
      hs += int'(req0_ready_o && req0_valid_i);
      hs += int'(req1_ready_o && req1_valid_i);
      cyc++;
      if (hs < n) @(posedge clk_i);
    end
    if (hs < n) begin
      nvec++;
      nerr++;
      $display("FAIL handshake_timeout: got %0d handshakes, want %0d", hs, n);
    end
  endtask

  task automatic single(input logic id, input logic [1:0] s,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] r, input logic z, input logic n);
    push(id, r, z, n);
    drive(id, 1'b1, s, a, b);
    wait_hs(1);
    step();
    drive(id, 1'b0, s, a, b);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_outputs"},
          {23'd0, res_valid_o, res_o, res_id_o, zero_o, neg_o},
          32'd0);
  endtask

  initial begin
    step();
    step();
    check_zero_outputs("reset");
    rst_ni = 1'b1;

    // ADD 5+3 from req0
    single(1'b0, ADD, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
    step();
    step();

    // fresh reset, then contention alternates 0,1,0,1
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    push(1'b0, 8'hFE, 1'b0, 1'b1);
    push(1'b1, 8'h00, 1'b1, 1'b0);
    push(1'b0, 8'hFE, 1'b0, 1'b1);
    push(1'b1, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 1'b1, SUB, 8'h03, 8'h05);
    drive(1'b1, 1'b1, AND, 8'hF0, 8'h0F);
    wait_hs(4);
    step();
    drive(1'b0, 1'b0, SUB, 8'h03, 8'h05);
    drive(1'b1, 1'b0, AND, 8'hF0, 8'h0F);
    step();

    // backpressure: OR result held while consumer stalls
    res_ready_i = 1'b0;
    single(1'b0, OR, 8'h80, 8'h01, 8'h81, 1'b0, 1'b1);
    push(1'b1, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 1'b1, ADD, 8'hFF, 8'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("stall_state",
            {26'd0, res_valid_o, neg_o, res_o == 8'h81,
             req0_ready_o, req1_ready_o, zero_o},
            32'b111000);
    end
    step();
    res_ready_i = 1'b1;
    @(negedge clk_i);
    check("release_accept", {31'd0, req1_ready_o}, 32'd1);
    step();
    drive(1'b1, 1'b0, ADD, 8'hFF, 8'h01);
    step();
    @(negedge clk_i);
    check("drain_valid", {31'd0, res_valid_o}, 32'd0);

    // idle cycles must not rotate priority (last grant = req1)
    step();
    step();
    step();
    push(1'b0, 8'h3F, 1'b0, 1'b0);
    push(1'b1, 8'h0F, 1'b0, 1'b0);
    drive(1'b0, 1'b1, OR, 8'h0F, 8'h30);
    drive(1'b1, 1'b1, SUB, 8'h10, 8'h01);
    wait_hs(2);
    step();
    drive(1'b0, 1'b0, OR, 8'h0F, 8'h30);
    drive(1'b1, 1'b0, SUB, 8'h10, 8'h01);
    step();

    // reset with a full buffer and both requests pending
    res_ready_i = 1'b0;
    single(1'b0, ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
    drive(1'b0, 1'b1, AND, 8'hFF, 8'h80);
    drive(1'b1, 1'b1, OR, 8'h00, 8'h00);
    rst_ni = 1'b0;
    res_ready_i = 1'b1;
    @(negedge clk_i);
    check("ready_in_reset", {30'd0, req0_ready_o, req1_ready_o}, 32'd0);
    exp_q.delete();
    step();
    check_zero_outputs("mid_reset");
    push(1'b0, 8'h80, 1'b0, 1'b1);
    push(1'b1, 8'h00, 1'b1, 1'b0);
    rst_ni = 1'b1;
    wait_hs(2);
    step();
    drive(1'b0, 1'b0, AND, 8'hFF, 8'h80);
    drive(1'b1, 1'b0, OR, 8'h00, 8'h00);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
